// File: rtl/sram8_bridge_pkg.sv
`default_nettype none
// ============================================================================
// Module  : sram8_bridge_pkg
// Brief   : Shared FSM states, lane constants and lane-search helper for the
//           32-bit to 8-bit SRAM bridge.
// Rev     : 1.0
// ============================================================================
package sram8_bridge_pkg;

    localparam int c_LANE_IDX_W = 2;
    localparam int c_LANES      = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_READ  = 3'd1,
        ST_RLAST = 3'd2,
        ST_WRITE = 3'd3,
        ST_DONE  = 3'd4
    } state_e;

    // Lowest set lane at or above 'from'; 3'd4 (bit 2 set) when none remains.
    function automatic logic [2:0] next_lane(input logic [3:0] strb, input logic [2:0] from);
        logic [2:0] r;
        r = 3'd4;
        for (int i = c_LANES - 1; i >= 0; i--) begin
            if (strb[i] && (i >= int'(from))) begin
                r = 3'(i);
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/sram8_word_bridge.sv
`default_nettype none
// ============================================================================
// Module  : sram8_word_bridge
// Brief   : Serializes picorv32 native-bus word accesses into little-endian
//           byte cycles on a single 8-bit registered-output SRAM.
//           Build option: SRAM8_BRIDGE_WSKIP_EN (write only strobed lanes).
// Rev     : 1.0
// ============================================================================
module sram8_word_bridge
    import sram8_bridge_pkg::*;
#(
    parameter int SRAM_ADDR_WIDTH = 13
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       sel,
    input  logic                       mem_valid,
    output logic                       mem_ready,
    input  logic [31:0]                mem_addr,
    input  logic [31:0]                mem_wdata,
    input  logic [3:0]                 mem_wstrb,
    output logic [31:0]                mem_rdata,
    output logic                       sram_ce,
    output logic                       sram_wre,
    output logic [SRAM_ADDR_WIDTH-1:0] sram_addr,
    output logic [7:0]                 sram_data_in,
    input  logic [7:0]                 sram_data_out
);

    localparam int c_WADDR_W = SRAM_ADDR_WIDTH - c_LANE_IDX_W;

    state_e                  state_q, state_d;
    logic [c_LANE_IDX_W-1:0] idx_q, idx_d, prev_lane;
    logic [c_WADDR_W-1:0]    waddr_q, waddr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [31:0]             rdata_q, rdata_d;
    logic                    unused_addr_bits;

`ifdef SRAM8_BRIDGE_WSKIP_EN
    logic [2:0] first_lane;
    logic [2:0] nxt_lane;
    assign first_lane = next_lane(mem_wstrb, 3'd0);
    assign nxt_lane   = next_lane(wstrb_q, {1'b0, idx_q} + 3'd1);
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= ST_IDLE;
            idx_q   <= '0;
            waddr_q <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            waddr_q <= waddr_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            rdata_q <= rdata_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        waddr_d   = waddr_q;
        wdata_d   = wdata_q;
        wstrb_d   = wstrb_q;
        rdata_d   = rdata_q;
        mem_ready = 1'b0;
        sram_ce   = 1'b0;
        sram_wre  = 1'b0;
        prev_lane = idx_q - 2'd1;

        unique case (state_q)
            ST_IDLE: begin
                if (mem_valid && sel) begin
                    waddr_d = mem_addr[SRAM_ADDR_WIDTH-1:2];
                    wdata_d = mem_wdata;
                    wstrb_d = mem_wstrb;
                    idx_d   = '0;
                    if (mem_wstrb == 4'd0) begin
                        state_d = ST_READ;
                    end else begin
                        state_d = ST_WRITE;
`ifdef SRAM8_BRIDGE_WSKIP_EN
                        idx_d   = first_lane[1:0];
`endif
                    end
                end
            end
            ST_READ: begin
                sram_ce = 1'b1;
                // SRAM output lags the issued address by one edge.
                if (idx_q != '0) begin
                    rdata_d[{prev_lane, 3'b000} +: 8] = sram_data_out;
                end
                idx_d = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_RLAST;
                end
            end
            ST_RLAST: begin
                rdata_d[31:24] = sram_data_out;
                state_d        = ST_DONE;
            end
            ST_WRITE: begin
                sram_wre = 1'b1;
`ifdef SRAM8_BRIDGE_WSKIP_EN
                sram_ce  = 1'b1;
                if (nxt_lane[2]) begin
                    state_d = ST_DONE;
                end else begin
                    idx_d   = nxt_lane[1:0];
                end
`else
                sram_ce  = wstrb_q[idx_q];
                idx_d    = idx_q + 2'd1;
                if (idx_q == 2'd3) begin
                    state_d = ST_DONE;
                end
`endif
            end
            ST_DONE: begin
                mem_ready = 1'b1;
                idx_d     = '0;
                state_d   = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign sram_addr        = {waddr_q, idx_q};
    assign sram_data_in     = wdata_q[{idx_q, 3'b000} +: 8];
    assign mem_rdata        = rdata_q;
    assign unused_addr_bits = ^{mem_addr[31:SRAM_ADDR_WIDTH], mem_addr[1:0]};

endmodule
`default_nettype wire

// File: tb/tb_sram8_word_bridge.sv
`default_nettype none
// ============================================================================
// Module  : tb_sram8_word_bridge
// Brief   : Self-checking bench: byte-wide SRAM model behind the bridge and a
//           word/strobe reference memory for directed and random traffic.
// Rev     : 1.0
// ============================================================================
module tb_sram8_word_bridge;

    localparam int AW    = 13;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          sel = 1'b0;
    logic          mem_valid = 1'b0;
    logic          mem_ready;
    logic [31:0]   mem_addr = '0;
    logic [31:0]   mem_wdata = '0;
    logic [3:0]    mem_wstrb = '0;
    logic [31:0]   mem_rdata;
    logic          sram_ce;
    logic          sram_wre;
    logic [AW-1:0] sram_addr;
    logic [7:0]    sram_data_in;
    logic [7:0]    sram_data_out;

    always #5 clk = ~clk;

    sram8_word_bridge #(.SRAM_ADDR_WIDTH(AW)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .sel          (sel),
        .mem_valid    (mem_valid),
        .mem_ready    (mem_ready),
        .mem_addr     (mem_addr),
        .mem_wdata    (mem_wdata),
        .mem_wstrb    (mem_wstrb),
        .mem_rdata    (mem_rdata),
        .sram_ce      (sram_ce),
        .sram_wre     (sram_wre),
        .sram_addr    (sram_addr),
        .sram_data_in (sram_data_in),
        .sram_data_out(sram_data_out)
    );

    // Byte-wide RAM with registered read data.
    bit [7:0] sram_mem [DEPTH];
    bit [7:0] sram_q;
    assign sram_data_out = sram_q;
    always @(posedge clk) begin
        if (sram_ce) begin
            if (sram_wre) sram_mem[sram_addr] <= sram_data_in;
            else          sram_q <= sram_mem[sram_addr];
        end
    end

    int            ready_cnt = 0;
    int            ce_cnt = 0;
    int            wr_cnt = 0;
    logic [AW-1:0] last_wr_addr = '0;
    always @(negedge clk) begin
        if (mem_ready) ready_cnt <= ready_cnt + 1;
        if (sram_ce) ce_cnt <= ce_cnt + 1;
        if (sram_ce && sram_wre) begin
            wr_cnt       <= wr_cnt + 1;
            last_wr_addr <= sram_addr;
        end
    end

    bit [7:0]    ref_mem [DEPTH];
    logic [31:0] exp_rdata = '0;
    int          checks = 0;
    int          errors = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ref_read(input logic [31:0] a);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        return {ref_mem[b + AW'(3)], ref_mem[b + AW'(2)], ref_mem[b + AW'(1)], ref_mem[b]};
    endfunction

    task automatic ref_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [AW-1:0] b;
        b = {a[AW-1:2], 2'b00};
        for (int l = 0; l < 4; l++) begin
            if (ws[l]) ref_mem[b + AW'(l)] = wd[8*l +: 8];
        end
    endtask

    function automatic int wr_lat(input logic [3:0] ws);
`ifdef SRAM8_BRIDGE_WSKIP_EN
        return $countones(ws);
`else
        return (ws == 4'd0) ? 4 : 4;
`endif
    endfunction

    // Called #1 after a rising edge; returns #1 after the edge leaving DONE.
    task automatic do_req(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws,
                          output logic [31:0] rd, output int lat);
        bit seen;
        int r0;
        seen = 1'b0;
        lat  = 0;
        rd   = '0;
        r0   = ready_cnt;
        mem_valid = 1'b1; sel = 1'b1;
        mem_addr = a; mem_wdata = wd; mem_wstrb = ws;
        @(posedge clk); #1;
        mem_addr = $urandom; mem_wdata = $urandom; mem_wstrb = 4'($urandom);
        for (int k = 0; k < 16 && !seen; k++) begin
            @(negedge clk);
            if (mem_ready === 1'b1) begin
                seen = 1'b1;
                rd   = mem_rdata;
            end else begin
                lat++;
            end
        end
        check("ready_seen", 32'(seen), 32'd1);
        @(posedge clk); #1;
        check("ready_one_cycle", 32'(mem_ready), 32'd0);
        check("ready_count", 32'(ready_cnt - r0), 32'd1);
        mem_valid = 1'b0;
        sel = 1'($urandom);
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] ws);
        logic [31:0] rd;
        int lat;
        do_req(a, wd, ws, rd, lat);
        ref_write(a, wd, ws);
        check("wr_latency", 32'(lat), 32'(wr_lat(ws)));
        check("rdata_hold", mem_rdata, exp_rdata);
    endtask

    task automatic rd_chk(input logic [31:0] a, output logic [31:0] rd);
        int lat;
        do_req(a, 32'd0, 4'd0, rd, lat);
        exp_rdata = ref_read(a);
        check("rd_data", rd, exp_rdata);
        check("rd_latency", 32'(lat), 32'd5);
    endtask

    initial begin
        logic [31:0] rd, a, wd;
        logic [3:0]  ws;
        int          w0, r0, c0;

        repeat (3) @(posedge clk);
        #1;
        check("rst_rdata", mem_rdata, 32'd0);
        check("rst_ctrl", 32'({mem_ready, sram_ce, sram_wre}), 32'd0);
        check("rst_addr", 32'(sram_addr), 32'd0);
        check("rst_din", 32'(sram_data_in), 32'd0);
        reset_n = 1'b1;
        @(posedge clk); #1;

        // Full word write and readback
        wr(32'h10, 32'hDEADBEEF, 4'hF);
        check("sram_bytes", {sram_mem[19], sram_mem[18], sram_mem[17], sram_mem[16]}, 32'hDEADBEEF);
        rd_chk(32'h10, rd);
        check("full_word", rd, 32'hDEADBEEF);

        // Single byte write
        w0 = wr_cnt;
        wr(32'h10, 32'h0000AA00, 4'b0010);
        check("byte_wr_count", 32'(wr_cnt - w0), 32'd1);
        check("byte_wr_addr", 32'(last_wr_addr), 32'h11);
        rd_chk(32'h10, rd);
        check("byte_merge", rd, 32'hDEADAAEF);

        // Reset in the middle of a read (READ, idx=2)
        mem_valid = 1'b1; sel = 1'b1; mem_addr = 32'h10; mem_wstrb = 4'd0;
        @(posedge clk); @(posedge clk); @(posedge clk); #1;
        check("mid_read_addr", 32'(sram_addr), 32'h12);
        r0 = ready_cnt;
        reset_n = 1'b0; mem_valid = 1'b0;
        #1;
        check("midrst_rdata", mem_rdata, 32'd0);
        check("midrst_ctrl", 32'({mem_ready, sram_ce, sram_wre}), 32'd0);
        check("midrst_addr", 32'(sram_addr), 32'd0);
        check("midrst_din", 32'(sram_data_in), 32'd0);
        @(posedge clk); #1;
        reset_n = 1'b1;
        exp_rdata = '0;
        @(posedge clk); #1;
        check("midrst_no_ready", 32'(ready_cnt - r0), 32'd0);
        rd_chk(32'h10, rd);

        // Deselected request
        c0 = ce_cnt; r0 = ready_cnt;
        mem_valid = 1'b1; sel = 1'b0; mem_addr = 32'h10; mem_wstrb = 4'hF;
        repeat (20) @(posedge clk);
        #1;
        mem_valid = 1'b0;
        check("desel_ce", 32'(ce_cnt - c0), 32'd0);
        check("desel_ready", 32'(ready_cnt - r0), 32'd0);

        // Back-to-back read then write
        for (int i = 0; i < 3; i++) begin
            rd_chk(32'h10 + 32'(4 * i), rd);
            wr(32'h40 + 32'(4 * i), $urandom, 4'hF);
        end

        // High address bits alias onto the SRAM
        wr(32'hFFFF2004, 32'h11223344, 4'hF);
        rd_chk(32'h00000004, rd);
        check("alias", rd, 32'h11223344);

        // Random traffic
        for (int i = 0; i < 40; i++) begin
            a  = $urandom;
            a  = a & 32'hFFFFE07F;
            wd = $urandom;
            ws = 4'($urandom);
            if (ws == 4'd0 || ($urandom_range(0, 3) == 0)) rd_chk(a, rd);
            else                                            wr(a, wd, ws);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
